// File: rtl/xadc_drp_sequencer.sv
// xadc_drp_sequencer
// Reads the XADC result register of each enabled auxiliary channel over the
// DRP after every end-of-conversion pulse and emits one tagged sample per
// channel, lowest channel first.
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   eoc             XADC end-of-conversion pulse
//   ch_enable[3:0]  channel enable mask, snapshotted at scan start
//   drp_do, drp_drdy  DRP read data / data-ready strobe
//   drp_den, drp_dwe, drp_daddr, drp_di  DRP request (read only)
//   sample_data, sample_ch, sample_valid  captured sample stream
//   busy            high whenever a scan is in progress
//   timeout_flag    sticky, a channel read was abandoned
//   overrun_flag    sticky, an eoc was lost
//   flag_clear      clears both sticky flags (a simultaneous set wins)
module xadc_drp_sequencer #(
  parameter logic [6:0] CH0_ADDR       = 7'h1F,
  parameter logic [6:0] CH1_ADDR       = 7'h1E,
  parameter logic [6:0] CH2_ADDR       = 7'h16,
  parameter logic [6:0] CH3_ADDR       = 7'h17,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eoc,
  input  logic [3:0]  ch_enable,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  output logic [15:0] sample_data,
  output logic [1:0]  sample_ch,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_flag,
  output logic        overrun_flag,
  input  logic        flag_clear
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RDY, S_NEXT} state_e;

  localparam logic [7:0] TERM_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        pending_q, pending_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        den_q, den_d;
  logic [6:0]  daddr_q, daddr_d;
  logic [15:0] sdata_q, sdata_d;
  logic [1:0]  sch_q, sch_d;
  logic        svalid_q, svalid_d;
  logic        busy_q, busy_d;
  logic        tflag_q, tflag_d;
  logic        oflag_q, oflag_d;

  logic        capture, tmo_hit, ovr_hit;
  logic [3:0]  scan_mask;
  logic [2:0]  scan_from;
  logic [2:0]  scan_nxt;   // {found, index}

  // Lowest set bit of m at or above position 'from'.
  function automatic logic [2:0] first_set(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--)
      if (m[i] && 3'(i) >= from) r = {1'b1, 2'(i)};
    return r;
  endfunction

  function automatic logic [6:0] ch_addr(input logic [1:0] p);
    logic [6:0] a;
    case (p)
      2'd0:    a = CH0_ADDR;
      2'd1:    a = CH1_ADDR;
      2'd2:    a = CH2_ADDR;
      default: a = CH3_ADDR;
    endcase
    return a;
  endfunction

  // One priority search serves both scan start (live mask from bit 0) and
  // advance (snapshot mask from ptr+1).
  always_comb begin
    scan_mask = (state_q == S_IDLE) ? ch_enable : mask_q;
    scan_from = (state_q == S_IDLE) ? 3'd0 : ({1'b0, ptr_q} + 3'd1);
    scan_nxt  = first_set(scan_mask, scan_from);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      ptr_q     <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    tmo_hit   = 1'b0;
    ovr_hit   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((eoc || pending_q) && ch_enable != 4'd0) begin
          mask_d    = ch_enable;
          ptr_d     = scan_nxt[1:0];
          pending_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        // drdy on the terminal count still wins over the timeout
        if (drp_drdy) begin
          capture = 1'b1;
          state_d = S_NEXT;
        end else if (cnt_q == TERM_CNT) begin
          tmo_hit = 1'b1;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_NEXT: begin
        if (scan_nxt[2]) begin
          ptr_d   = scan_nxt[1:0];
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Only one eoc can be queued; a second one while queued is lost.
    if (eoc && state_q != S_IDLE) begin
      if (pending_q) ovr_hit = 1'b1;
      pending_d = 1'b1;
    end
  end

  // Outputs, computed from the next state so they are registered and aligned
  always_comb begin
    den_d    = (state_d == S_ISSUE);
    daddr_d  = (state_d == S_ISSUE) ? ch_addr(ptr_d) : daddr_q;
    sdata_d  = capture ? drp_do : sdata_q;
    sch_d    = capture ? ptr_q : sch_q;
    svalid_d = capture;
    busy_d   = (state_d != S_IDLE);
    tflag_d  = tmo_hit | (tflag_q & ~flag_clear);
    oflag_d  = ovr_hit | (oflag_q & ~flag_clear);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      den_q    <= 1'b0;
      daddr_q  <= '0;
      sdata_q  <= '0;
      sch_q    <= '0;
      svalid_q <= 1'b0;
      busy_q   <= 1'b0;
      tflag_q  <= 1'b0;
      oflag_q  <= 1'b0;
    end else begin
      den_q    <= den_d;
      daddr_q  <= daddr_d;
      sdata_q  <= sdata_d;
      sch_q    <= sch_d;
      svalid_q <= svalid_d;
      busy_q   <= busy_d;
      tflag_q  <= tflag_d;
      oflag_q  <= oflag_d;
    end
  end

  assign drp_den      = den_q;
  assign drp_dwe      = 1'b0;
  assign drp_daddr    = daddr_q;
  assign drp_di       = '0;
  assign sample_data  = sdata_q;
  assign sample_ch    = sch_q;
  assign sample_valid = svalid_q;
  assign busy         = busy_q;
  assign timeout_flag = tflag_q;
  assign overrun_flag = oflag_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
module tb_xadc_drp_sequencer;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        eoc = 1'b0;
  logic [3:0]  ch_enable = 4'd0;
  logic [15:0] drp_do = 16'd0;
  logic        drp_drdy = 1'b0;
  logic        flag_clear = 1'b0;
  logic        drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di, sample_data;
  logic [1:0]  sample_ch;
  logic        sample_valid, busy, timeout_flag, overrun_flag;

  xadc_drp_sequencer dut (
    .clk(clk), .reset(reset), .eoc(eoc), .ch_enable(ch_enable),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .sample_data(sample_data),
    .sample_ch(sample_ch), .sample_valid(sample_valid), .busy(busy),
    .timeout_flag(timeout_flag), .overrun_flag(overrun_flag), .flag_clear(flag_clear)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [6:0] addr; logic [15:0] data; int lat; bit answer; bit emit; } rd_t;
  typedef struct { logic [1:0] ch; logic [15:0] data; } smp_t;

  rd_t  resp_q[$];   // planned DRP reads, in order
  smp_t exp_q[$];    // expected samples, in order
  int   vcyc_q[$];   // expected sample_valid cycle per emitted sample
  int   den_q[$];    // observed drp_den cycles
  int   pass_cnt = 0, total_cnt = 0;
  int   eoc_cyc;
  bit   exp_tflag = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [6:0] addr_of(input int ch);
    case (ch)
      0: return 7'h1F;
      1: return 7'h1E;
      2: return 7'h16;
      default: return 7'h17;
    endcase
  endfunction

  // Reference model: a scan reads every enabled channel in ascending order;
  // each answered read yields one sample, an unanswered one sets the timeout flag.
  task automatic plan_scan(input logic [3:0] m, input int lat, input logic [3:0] noans,
                           input bit fixed, input logic [15:0] fdata, input bit emit_ok);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        rd_t r;
        r.addr   = addr_of(i);
        r.data   = fixed ? fdata : 16'($urandom);
        r.lat    = (lat > 0) ? lat : int'($urandom_range(1, 8));
        r.answer = !noans[i];
        r.emit   = r.answer && emit_ok;
        resp_q.push_back(r);
        if (r.emit) exp_q.push_back('{ch: 2'(i), data: r.data});
        if (!r.answer) exp_tflag = 1;
      end
    end
  endtask

  // DRP responder: answers each drp_den from the plan after the planned latency.
  initial begin
    forever begin
      @(negedge clk);
      if (drp_den) begin
        den_q.push_back(cyc);
        if (resp_q.size() == 0) begin
          check("unexpected_den", {25'd0, drp_daddr}, 32'hFFFF_FFFF);
        end else begin
          rd_t r;
          int  c;
          r = resp_q.pop_front();
          c = cyc;
          check("daddr", {25'd0, drp_daddr}, {25'd0, r.addr});
          if (r.answer) begin
            if (r.emit) vcyc_q.push_back(c + r.lat + 1);
            repeat (r.lat) @(negedge clk);
            drp_do   = r.data;
            drp_drdy = 1'b1;
            @(negedge clk);
            drp_drdy = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a sample is presented.
  bit prev_den = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (drp_den) begin
        check("den_single_cycle", {31'd0, prev_den}, 32'd0);
        check("dwe_di_zero", {15'd0, drp_dwe, drp_di}, 32'd0);
      end
      prev_den = drp_den;
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", {14'd0, sample_ch, sample_data}, 32'hFFFF_FFFF);
        end else begin
          smp_t s;
          s = exp_q.pop_front();
          check("sample_data", {16'd0, sample_data}, {16'd0, s.data});
          check("sample_ch", {30'd0, sample_ch}, {30'd0, s.ch});
          if (vcyc_q.size() == 0) check("valid_timing", cyc, 32'hFFFF_FFFF);
          else check("valid_timing", cyc, vcyc_q.pop_front());
        end
      end
    end
  end

  task automatic pulse_eoc();
    @(negedge clk);
    eoc_cyc = cyc;
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
  endtask

  // Idle means busy low for 3 consecutive cycles (a pending rescan dips for one).
  task automatic wait_idle(input int budget);
    int n = 0, quiet = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy) quiet++; else quiet = 0;
    end
    check("idle_reached", {31'd0, quiet >= 3}, 32'd1);
    check("reads_consumed", resp_q.size(), 0);
    check("samples_seen", exp_q.size(), 0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_den", {31'd0, drp_den}, 0);
    check("rst_dwe", {31'd0, drp_dwe}, 0);
    check("rst_daddr", {25'd0, drp_daddr}, 0);
    check("rst_di", {16'd0, drp_di}, 0);
    check("rst_sdata", {16'd0, sample_data}, 0);
    check("rst_sch", {30'd0, sample_ch}, 0);
    check("rst_svalid", {31'd0, sample_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_tflag", {31'd0, timeout_flag}, 0);
    check("rst_oflag", {31'd0, overrun_flag}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single channel, drdy two cycles after den
    ch_enable = 4'b0001;
    den_q.delete();
    plan_scan(4'b0001, 2, 4'b0000, 1'b1, 16'hABC0, 1'b1);
    pulse_eoc();
    wait_idle(200);
    check("eoc_to_den", (den_q.size() > 0) ? den_q[0] - eoc_cyc : -1, 1);

    // Sparse mask
    ch_enable = 4'b1010;
    plan_scan(4'b1010, 0, 4'b0000, 1'b0, 16'h0, 1'b1);
    pulse_eoc();
    wait_idle(200);
    check("daddr_holds", {25'd0, drp_daddr}, 32'h17);
    check("tflag_clear_before", {31'd0, timeout_flag}, 0);

    // Timeout on channel 0, channel 1 still read
    ch_enable = 4'b0011;
    den_q.delete();
    plan_scan(4'b0011, 2, 4'b0001, 1'b0, 16'h0, 1'b1);
    pulse_eoc();
    repeat (TMO) @(negedge clk);
    check("tflag_before_tc", {31'd0, timeout_flag}, 0);
    @(negedge clk);
    check("tflag_after_tc", {31'd0, timeout_flag}, 1);
    wait_idle(400);
    check("timeout_gap", (den_q.size() > 1) ? den_q[1] - den_q[0] : -1, TMO + 2);

    // Pending and overrun: one rescan only
    ch_enable = 4'b0111;
    plan_scan(4'b0111, 0, 4'b0000, 1'b0, 16'h0, 1'b1);
    plan_scan(4'b0111, 0, 4'b0000, 1'b0, 16'h0, 1'b1);
    pulse_eoc();
    pulse_eoc();
    check("oflag_after_one", {31'd0, overrun_flag}, 0);
    pulse_eoc();
    check("oflag_after_two", {31'd0, overrun_flag}, 1);
    wait_idle(400);
    check("tflag_sticky", {31'd0, timeout_flag}, 1);
    @(negedge clk); flag_clear = 1'b1;
    @(negedge clk); flag_clear = 1'b0;
    check("tflag_cleared", {31'd0, timeout_flag}, 0);
    check("oflag_cleared", {31'd0, overrun_flag}, 0);
    exp_tflag = 0;

    // drdy on the terminal count is a capture, not a timeout
    ch_enable = 4'b0001;
    plan_scan(4'b0001, TMO, 4'b0000, 1'b0, 16'h0, 1'b1);
    pulse_eoc();
    wait_idle(400);
    check("tc_capture_no_tflag", {31'd0, timeout_flag}, 0);

    // Mid-scan mask change during the channel 1 read
    ch_enable = 4'b1111;
    plan_scan(4'b1111, 3, 4'b0000, 1'b0, 16'h0, 1'b1);
    pulse_eoc();
    repeat (7) @(negedge clk);
    ch_enable = 4'b0001;
    wait_idle(200);
    plan_scan(4'b0001, 0, 4'b0000, 1'b0, 16'h0, 1'b1);
    pulse_eoc();
    wait_idle(200);

    // Zero mask discards eoc
    ch_enable = 4'b0000;
    pulse_eoc();
    repeat (3) @(negedge clk);
    check("zero_mask_idle", {31'd0, busy}, 0);
    check("zero_mask_no_ovr", {31'd0, overrun_flag}, 0);

    // Randomized scans
    for (int k = 0; k < 20; k++) begin
      logic [3:0] m, na;
      m  = 4'($urandom_range(0, 15));
      na = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
      ch_enable = m;
      if (m == 4'd0) begin
        pulse_eoc();
        repeat (3) @(negedge clk);
        check("rand_zero_idle", {31'd0, busy}, 0);
      end else begin
        plan_scan(m, 0, na, 1'b0, 16'h0, 1'b1);
        pulse_eoc();
        wait_idle(500);
      end
    end
    check("rand_tflag", {31'd0, timeout_flag}, {31'd0, exp_tflag});

    // Async reset while in WAIT_RDY, drdy arrives after reset
    ch_enable = 4'b0001;
    plan_scan(4'b0001, 10, 4'b0000, 1'b0, 16'h0, 1'b0);
    pulse_eoc();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async_busy", {31'd0, busy}, 0);
    check("rst_async_den", {31'd0, drp_den}, 0);
    check("rst_async_valid", {31'd0, sample_valid}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("late_drdy_busy", {31'd0, busy}, 0);
    check("late_drdy_sdata", {16'd0, sample_data}, 0);
    check("late_drdy_reads", resp_q.size(), 0);
    check("late_drdy_samples", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
